sram22_arbiter: RTL
===================

# sram22_arbiter

Two-requester round-robin controller that shares one single-port sram22 macro (64x32, 8-bit nibble write mask, 1-cycle registered read) between two independent clients. It sits directly in front of the macro, drives its clk-synchronous we/wmask/addr/din pins, and turns the macro's unbuffered dout into per-requester valid/ready read responses with local holding registers.

## Interface
- DATA_WIDTH, 32, macro word width
- ADDR_WIDTH, 6, macro address width
- WMASK_WIDTH, 8, write-mask bits; each bit covers DATA_WIDTH/WMASK_WIDTH = 4 data bits
- clk  in  1  clock, shared with the macro
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted this cycle (one-hot or zero)
- req_we  in  2  1 = write, 0 = read
- req_wmask  in  2*WMASK_WIDTH  per-requester write mask, requester i in slice i
- req_addr  in  2*ADDR_WIDTH  per-requester address
- req_wdata  in  2*DATA_WIDTH  per-requester write data
- rsp_valid  out  2  read data valid for requester i
- rsp_ready  in  2  requester i consumes response
- rsp_rdata  out  2*DATA_WIDTH  read data, requester i in slice i
- sram_we, sram_wmask, sram_addr, sram_din  out  1/WMASK_WIDTH/ADDR_WIDTH/DATA_WIDTH  to macro
- sram_dout  in  DATA_WIDTH  from macro

## Operation
- Eligibility: requester i eligible iff req_valid[i] and (write, or read with pend_i==0 and (rsp_valid[i]==0 or rsp_ready[i]==1)).
- Grant: at most one per cycle. If both eligible, grant goes to the priority pointer; otherwise to the single eligible one. The pointer moves to the other requester after every grant and holds when there is no grant.
- req_ready[i] = grant[i], combinational. It depends on req_valid, so requesters must not make valid depend on ready.
- Granted request drives the sram_* pins combinationally in the same cycle.
- With no grant: sram_we=0, sram_wmask=0. sram_addr/sram_din hold their last driven values, so the idle read is harmless.
- Granted read sets pend_i=1 and records the port id. Next cycle, sram_dout is captured into rsp_rdata slice i; rsp_valid[i] rises and pend_i clears.
- A rsp_valid/rsp_ready handshake clears rsp_valid[i]. Simultaneous capture and consume: the new data wins and rsp_valid stays 1.
- Writes produce no response. sram_dout during the cycle after a write is X and is never captured.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, pend=0, pointer=requester 0, sram_we=0, sram_wmask=0, sram_addr=0, sram_din=0. req_ready=0 while rst=1.
- Read latency: accepted in cycle t; rsp_valid in cycle t+2.
- Per-requester read issue: at most once every 2 cycles. Aggregate throughput: 1 access per cycle when the two requesters alternate.
- Write accepted in cycle t is visible to a read accepted in cycle t+1 (RAW to the same address returns new data).
- Read at t followed by a write at t+1 to the same address returns old data.
- rst asserted mid-operation: pending reads are discarded, held responses dropped, and the pointer resets. No sram write is issued in the reset cycle.

## Structure
- Package sram22_ctrl_pkg holds:
  - DATA_WIDTH/ADDR_WIDTH/WMASK_WIDTH defaults
  - the derived NIBBLE_WIDTH
  - port_id_t (1 bit)
  - the request struct (we, wmask, addr, wdata)
- Sub-module rr_arb2: 2-way round-robin arbiter; eligible in, one-hot grant out, internal pointer updated on grant.
- Top level contains eligibility logic, the sram_* mux, and per-port pend/rsp registers.

## Test plan
- Reset then single write/read: req0 write addr 5, wdata 0xDEADBEEF, wmask 0xFF; then req0 read addr 5 -> rsp_valid[0] two cycles after accept, rdata 0xDEADBEEF.
- Nibble mask: write 0xFFFFFFFF to addr 9, then write 0x12345678 with wmask 0x0F, read addr 9 -> 0xFFFF5678.
- Contention: both requesters assert read continuously (addr 1 / addr 2, preloaded 0xA / 0xB) -> grants strictly alternate 0,1,0,1; each response carries its own port's data; no starvation.
- Backpressure: rsp_ready[1]=0 with rsp_valid[1]=1 -> a new read from requester 1 is held off (req_ready[1]=0) while requester 0 keeps being granted; raising rsp_ready[1] allows the grant in that same cycle.
- Hazards: write addr 3 = 0x11 at t, read addr 3 at t+1 -> 0x11. Read addr 4 (old 0x22) at t, write addr 4 = 0x33 at t+1 -> 0x22.
- Reset mid-read: rst asserted the cycle after a read accept -> rsp_valid stays 0, all outputs at reset values; a subsequent read returns correct data.

Source files
------------

// File: rtl/sram22_ctrl_pkg.sv
// Shared types and default geometry for the two-port sram22 arbiter.
// The request struct is sized from these defaults.
package sram22_ctrl_pkg;

    localparam int SRAM_DATA_WIDTH  = 32;
    localparam int SRAM_ADDR_WIDTH  = 6;
    localparam int SRAM_WMASK_WIDTH = 8;
    localparam int NIBBLE_WIDTH     = SRAM_DATA_WIDTH / SRAM_WMASK_WIDTH;

    typedef logic port_id_t;

    typedef struct packed {
        logic                        we;
        logic [SRAM_WMASK_WIDTH-1:0] wmask;
        logic [SRAM_ADDR_WIDTH-1:0]  addr;
        logic [SRAM_DATA_WIDTH-1:0]  wdata;
    } sram_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the favoured requester
// and flips to the other side after every grant.
module rr_arb2
    import sram22_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    port_id_t ptr_q;

    always_comb begin
        grant = eligible;
        if (&eligible) begin
            grant        = '0;
            grant[ptr_q] = 1'b1;
        end
    end

    // Granting port 0 favours port 1 next, and vice versa.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (|grant) begin
            ptr_q <= grant[0];
        end
    end

endmodule

// File: rtl/sram22_arbiter.sv
// Round-robin front end sharing one single-port sram22 macro between two
// clients, with per-port read response holding registers.
module sram22_arbiter
    import sram22_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH  = SRAM_ADDR_WIDTH,
    parameter int WMASK_WIDTH = SRAM_WMASK_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [1:0]               req_we,
    input  logic [2*WMASK_WIDTH-1:0] req_wmask,
    input  logic [2*ADDR_WIDTH-1:0]  req_addr,
    input  logic [2*DATA_WIDTH-1:0]  req_wdata,
    output logic [1:0]               rsp_valid,
    input  logic [1:0]               rsp_ready,
    output logic [2*DATA_WIDTH-1:0]  rsp_rdata,
    output logic                     sram_we,
    output logic [WMASK_WIDTH-1:0]   sram_wmask,
    output logic [ADDR_WIDTH-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0]    sram_din,
    input  logic [DATA_WIDTH-1:0]    sram_dout
);

    logic [1:0]                 eligible;
    logic [1:0]                 grant;
    logic                       granted;
    port_id_t                   sel_id;
    sram_req_t                  sel_req;
    logic [ADDR_WIDTH-1:0]      addr_hold;
    logic [DATA_WIDTH-1:0]      din_hold;
    logic [1:0]                 pend_p1;
    logic [1:0]                 rsp_vld_p2;
    logic [1:0][DATA_WIDTH-1:0] rsp_rdata_p2;

    // A read needs a free response slot by the time its data lands.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < 2; i++) begin
            eligible[i] = !rst && req_valid[i] &&
                          (req_we[i] || (!pend_p1[i] && (!rsp_vld_p2[i] || rsp_ready[i])));
        end
    end

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible),
        .grant    (grant)
    );

    assign req_ready = grant;
    assign granted   = |grant;

    always_comb begin
        sel_id        = grant[1];
        sel_req.we    = sel_id ? req_we[1] : req_we[0];
        sel_req.wmask = sel_id ? req_wmask[2*WMASK_WIDTH-1:WMASK_WIDTH] : req_wmask[WMASK_WIDTH-1:0];
        sel_req.addr  = sel_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]    : req_addr[ADDR_WIDTH-1:0];
        sel_req.wdata = sel_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]   : req_wdata[DATA_WIDTH-1:0];
    end

    // Stage p0: granted request straight onto the macro pins; address and
    // data hold when idle so the macro sees a harmless repeat read.
    assign sram_we    = granted && sel_req.we;
    assign sram_wmask = granted ? sel_req.wmask : '0;
    assign sram_addr  = granted ? sel_req.addr  : addr_hold;
    assign sram_din   = granted ? sel_req.wdata : din_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold <= '0;
            din_hold  <= '0;
        end else if (granted) begin
            addr_hold <= sel_req.addr;
            din_hold  <= sel_req.wdata;
        end
    end

    // Stage p1 -> p2: macro output is valid one cycle after a read grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_p1      <= '0;
            rsp_vld_p2   <= '0;
            rsp_rdata_p2 <= '0;
        end else begin
            pend_p1 <= grant & ~req_we;
            for (int i = 0; i < 2; i++) begin
                if (pend_p1[i]) begin
                    rsp_vld_p2[i]   <= 1'b1;
                    rsp_rdata_p2[i] <= sram_dout;
                end else if (rsp_ready[i]) begin
                    rsp_vld_p2[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = rsp_vld_p2;
    assign rsp_rdata = rsp_rdata_p2;

endmodule
